// File: rtl/btn_event_queue.sv
`default_nettype none
// ============================================================================
// Module   : btn_event_queue
// Purpose  : Collects one-cycle debounced press pulses from up to 2**CODE_W
//            buttons and turns them into a FIFO of button-index event codes.
//            Pulses are first latched in a per-button pending register.
//            Pending bits are then served lowest index first into a small
//            circular FIFO. Any press that cannot be recorded sets a sticky
//            overflow flag.
// Ports    : clk        - system clock
//            nrst       - asynchronous active-low reset
//            btn_pulse  - one-cycle press pulses, bit i = button i
//            evt_ready  - consumer accepts the head event this cycle
//            ovf_clr    - clears the sticky overflow flag
//            evt_valid  - FIFO non-empty
//            evt_code   - button index at the FIFO head (0 while empty)
//            count      - number of FIFO entries, 0..DEPTH
//            ovf        - sticky: at least one event was lost
// Revision : 1.0 - initial release
// ============================================================================
module btn_event_queue #(
    parameter int CODE_W = 3,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 3
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic [2**CODE_W-1:0]   btn_pulse,
    input  logic                   evt_ready,
    input  logic                   ovf_clr,
    output logic                   evt_valid,
    output logic [CODE_W-1:0]      evt_code,
    output logic [CNT_W-1:0]       count,
    output logic                   ovf
);

    localparam int               NUM_BTN = 2**CODE_W;
    localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [NUM_BTN-1:0] pending_q, pending_d;
    logic [PTR_W-1:0]   wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q,  rd_ptr_d;
    logic [CNT_W-1:0]   count_q,   count_d;
    logic               ovf_q,     ovf_d;
    logic [CODE_W-1:0]  mem_q [DEPTH];

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic               w_pop;
    logic               w_push;
    logic [CODE_W-1:0]  w_push_sel;
    logic [NUM_BTN-1:0] w_push_mask;
    logic [NUM_BTN-1:0] w_drop;

    // Pop is decided only from registered state plus evt_ready, so evt_ready
    // never reaches evt_valid/evt_code combinationally.
    assign w_pop = (count_q != '0) && evt_ready;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_push = (pending_q != '0) && ((count_q < C_DEPTH) || w_pop);

    // Lowest set pending index: scan from the top so the lowest wins.
    always_comb begin
        w_push_sel = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                w_push_sel = CODE_W'(i);
            end
        end
    end

    assign w_push_mask = w_push ? (NUM_BTN'(1) << w_push_sel) : '0;

    // A pulse on a bit that is pending and not leaving this cycle has no
    // place to go. A pulse on the bit being pushed simply re-arms it.
    assign w_drop = btn_pulse & pending_q & ~w_push_mask;

    always_comb begin
        pending_d = (pending_q & ~w_push_mask) | btn_pulse;

        wr_ptr_d  = w_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = w_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d   = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Set has priority over clear.
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (w_drop != '0) begin
            ovf_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pending_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage is not reset; the head is masked while empty instead.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= w_push_sel;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign evt_valid = (count_q != '0);
    assign evt_code  = evt_valid ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;
    assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_btn_event_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_event_queue
// Purpose  : Self-checking bench for btn_event_queue. Expected codes are
//            pushed to a scoreboard queue as presses are driven and popped
//            when the consumer handshake takes an event.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_event_queue;

    localparam int CODE_W = 3;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;

    logic              clk;
    logic              nrst;
    logic [7:0]        btn_pulse;
    logic              evt_ready;
    logic              ovf_clr;
    logic              evt_valid;
    logic [CODE_W-1:0] evt_code;
    logic [CNT_W-1:0]  count;
    logic              ovf;

    int checks;
    int errors;
    logic [CODE_W-1:0] exp_q[$];

    btn_event_queue #(
        .CODE_W (CODE_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .btn_pulse (btn_pulse),
        .evt_ready (evt_ready),
        .ovf_clr   (ovf_clr),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .count     (count),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit
    // after the edge.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle press pulse on a mask; expected codes queued lowest first.
    task automatic press(input logic [7:0] mask);
        btn_pulse = mask;
        for (int b = 0; b < 8; b++) begin
            if (mask[b]) exp_q.push_back(CODE_W'(b));
        end
        tick();
        btn_pulse = '0;
    endtask

    // Hold evt_ready and compare every taken event against the scoreboard.
    task automatic drain(input string name, input logic exp_ovf);
        int budget;
        budget = 40;
        evt_ready = 1'b1;
        while ((exp_q.size() != 0 || evt_valid) && budget > 0) begin
            if (evt_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s unexpected event code=%0d", name, evt_code);
                end else begin
                    logic [CODE_W-1:0] e;
                    e = exp_q.pop_front();
                    if (evt_code !== e) begin
                        errors++;
                        $display("FAIL %s code got=%0d exp=%0d", name, evt_code, e);
                    end
                end
            end
            tick();
            budget--;
        end
        evt_ready = 1'b0;
        checks++;
        if (budget == 0) begin
            errors++;
            $display("FAIL %s drain timeout, %0d events still expected", name, exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (ovf !== exp_ovf) begin
            errors++;
            $display("FAIL %s ovf got=%b exp=%b", name, ovf, exp_ovf);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        btn_pulse = '0;
        evt_ready = 1'b0;
        ovf_clr = 1'b0;
        #12;
        checks++;
        if ({evt_valid, evt_code, count, ovf} !== '0) begin
            errors++;
            $display("FAIL reset outputs got v=%b c=%0d n=%0d o=%b exp all 0",
                     evt_valid, evt_code, count, ovf);
        end
        nrst = 1'b1;
        tick(2);
    endtask

    task automatic test_single();
        press(8'h04);
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL single early valid got=%b exp=0", evt_valid);
        end
        tick();
        checks++;
        if (evt_valid !== 1'b1 || evt_code !== 3'd2 || count !== 3'd1) begin
            errors++;
            $display("FAIL single head got v=%b c=%0d n=%0d exp v=1 c=2 n=1",
                     evt_valid, evt_code, count);
        end
        drain("single", 1'b0);
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL single count after pop got=%0d exp=0", count);
        end
    endtask

    task automatic test_simultaneous();
        evt_ready = 1'b1;
        press(8'h21);
        drain("simultaneous", 1'b0);
    endtask

    task automatic test_backpressure();
        press(8'h02);
        press(8'h04);
        press(8'h08);
        press(8'h10);
        press(8'h40);
        tick(3);
        checks++;
        if (count !== 3'd4) begin
            errors++;
            $display("FAIL full count got=%0d exp=4", count);
        end
        // Single pop while full with button 6 still pending.
        checks++;
        if (evt_code !== exp_q[0]) begin
            errors++;
            $display("FAIL full head got=%0d exp=%0d", evt_code, exp_q[0]);
        end
        void'(exp_q.pop_front());
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        checks++;
        if (count !== 3'd4 || evt_code !== 3'd2) begin
            errors++;
            $display("FAIL pop+push got n=%0d c=%0d exp n=4 c=2", count, evt_code);
        end
        drain("backpressure", 1'b0);
    endtask

    task automatic test_overflow();
        press(8'h01);
        press(8'h02);
        press(8'h04);
        press(8'h10);
        press(8'h08);       // stays pending: FIFO full
        tick(2);
        btn_pulse = 8'h08;  // second press on pending button 3 is lost
        tick();
        btn_pulse = '0;
        tick(2);
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf set got=%b exp=1", ovf);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf clear got=%b exp=0", ovf);
        end
        ovf_clr = 1'b1;
        btn_pulse = 8'h08;
        tick();
        ovf_clr = 1'b0;
        btn_pulse = '0;
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf set-wins got=%b exp=1", ovf);
        end
        drain("overflow", 1'b1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
    endtask

    task automatic test_repress();
        press(8'h80);       // pending[7] set; pushed on the next edge
        press(8'h80);       // arrives exactly as index 7 is pushed
        tick(2);
        checks++;
        if (count !== 3'd2 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL repress got n=%0d o=%b exp n=2 o=0", count, ovf);
        end
        drain("repress", 1'b0);
    endtask

    task automatic test_reset_mid();
        btn_pulse = 8'h1F;
        tick();
        btn_pulse = '0;
        tick(3);
        checks++;
        if (count !== 3'd3) begin
            errors++;
            $display("FAIL mid fill count got=%0d exp=3", count);
        end
        btn_pulse = 8'h10;  // button 4 still pending and not pushed: drop
        tick();
        btn_pulse = '0;
        checks++;
        if (count !== 3'd4 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL mid pre-reset got n=%0d o=%b exp n=4 o=1", count, ovf);
        end
        #2;
        nrst = 1'b0;
        #2;
        checks++;
        if ({evt_valid, evt_code, count, ovf} !== '0) begin
            errors++;
            $display("FAIL mid reset got v=%b c=%0d n=%0d o=%b exp all 0",
                     evt_valid, evt_code, count, ovf);
        end
        nrst = 1'b1;
        exp_q.delete();
        tick();
        press(8'h02);
        tick(3);
        drain("after reset", 1'b0);
        tick(3);
        checks++;
        if (evt_valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL stale events got v=%b n=%0d exp v=0 n=0", evt_valid, count);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_overflow();
        test_repress();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
